// File: rtl/mix_pkg.sv
// mix_pkg: shared types and helpers for the mix_scheduler block.
//   MAG_W     - track / output magnitude width
//   magType   - unsigned magnitude
//   mixState  - sequencing states of the mix run
//   toSigned  - sign/magnitude to two's-complement conversion
package mix_pkg;

    localparam int MAG_W = 8;

    typedef logic [MAG_W-1:0] magType;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ACCUM,
        FINISH
    } mixState;

    // One extra bit holds -255 .. +255; a negative zero collapses to 0.
    function automatic logic signed [MAG_W:0] toSigned(input logic s, input magType m);
        logic signed [MAG_W:0] v;
        v = $signed({1'b0, m});
        return s ? -v : v;
    endfunction

endpackage

// File: rtl/mix_scheduler_if.sv
// mix_scheduler_if: track inputs and mixed outputs of the mix_scheduler.
//   master : drives wgEn, sign, magnitude, routeMask; observes the results
//   slave  : the mixer; drives outSign, outMagnitude, busy, overrun
//   routeMask[o][t] = 1 routes track t into output o.
interface mix_scheduler_if
    import mix_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 4
);
    logic                                   wgEn;
    logic [NUM_INPUTS-1:0]                  sign;
    magType [NUM_INPUTS-1:0]                magnitude;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] routeMask;
    logic [NUM_OUTPUTS-1:0]                 outSign;
    magType [NUM_OUTPUTS-1:0]               outMagnitude;
    logic                                   busy;
    logic                                   overrun;

    modport master (
        output wgEn, sign, magnitude, routeMask,
        input  outSign, outMagnitude, busy, overrun
    );

    modport slave (
        input  wgEn, sign, magnitude, routeMask,
        output outSign, outMagnitude, busy, overrun
    );
endinterface

// File: rtl/mixLane.sv
// mixLane: one output channel of the mixer.
//   clk, reset        - clock, synchronous active-high reset
//   clr               - clear the accumulator (start of a run)
//   en                - add track_val into the accumulator this cycle
//   fin               - convert the sum and load the output registers
//   track_val         - current track as a signed value
//   out_sign, out_mag - registered mixed sign/magnitude
// Build option MIX_SATURATE_EN: clip |sum| at 255 instead of scaling it
// down by $clog2(NUM_INPUTS).
module mixLane
    import mix_pkg::*;
#(
    parameter int NUM_INPUTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  fin,
    input  logic signed [MAG_W:0] track_val,
    output logic                  out_sign,
    output magType                out_mag
);
    localparam int ACC_W = 10 + $clog2(NUM_INPUTS);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic [ACC_W-1:0]        abs_v;
    magType                  mag_c;
    logic                    sign_c;

    assign ext = {{(ACC_W-MAG_W-1){track_val[MAG_W]}}, track_val};

    always_comb begin
        abs_v = acc[ACC_W-1] ? -acc : acc;
`ifdef MIX_SATURATE_EN
        mag_c = (abs_v > ACC_W'(255)) ? '1 : abs_v[MAG_W-1:0];
`else
        // Shifting the magnitude (not the signed sum) keeps +x and -x symmetric.
        mag_c = MAG_W'(abs_v >> $clog2(NUM_INPUTS));
`endif
        // A sum that scales to zero must not report a negative sign.
        sign_c = acc[ACC_W-1] && (mag_c != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            out_sign <= 1'b0;
            out_mag  <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + ext;
            end
            if (fin) begin
                out_sign <= sign_c;
                out_mag  <= mag_c;
            end
        end
    end
endmodule

// File: rtl/mix_scheduler.sv
// mix_scheduler: time-multiplexed track-to-output mixer.
//   clk, reset - 40 MHz clock, synchronous active-high reset
//   bus        - mix_scheduler_if.slave: wgEn strobe, per-track sign /
//                magnitude, routing mask in; mixed outSign / outMagnitude,
//                busy and sticky overrun out.
// A wgEn strobe waits one cycle (magnitudes settle), snapshots all inputs,
// then walks the tracks one per cycle into one accumulator per output.
// Build option MIX_SATURATE_EN selects clipping instead of scaling.
module mix_scheduler
    import mix_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 4
) (
    input logic             clk,
    input logic             reset,
    mix_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    mixState                                state;
    logic [IDX_W-1:0]                       idx;
    logic [NUM_INPUTS-1:0]                  sign_snap;
    magType [NUM_INPUTS-1:0]                mag_snap;
    logic [NUM_OUTPUTS-1:0][NUM_INPUTS-1:0] mask_snap;
    logic                                   busy_q;
    logic                                   overrun_q;

    logic signed [MAG_W:0]    track_val;
    logic [NUM_OUTPUTS-1:0]   out_sign;
    magType [NUM_OUTPUTS-1:0] out_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            sign_snap <= '0;
            mag_snap  <= '0;
            mask_snap <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.wgEn && state != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.wgEn) begin
                        state  <= CAPTURE;
                        busy_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    sign_snap <= bus.sign;
                    mag_snap  <= bus.magnitude;
                    mask_snap <= bus.routeMask;
                    idx       <= '0;
                    state     <= ACCUM;
                end
                ACCUM: begin
                    if (idx == IDX_W'(NUM_INPUTS - 1)) begin
                        state <= FINISH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign track_val = toSigned(sign_snap[idx], mag_snap[idx]);

    for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_lane
        mixLane #(
            .NUM_INPUTS(NUM_INPUTS)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clr       (state == CAPTURE),
            .en        (state == ACCUM && mask_snap[o][idx]),
            .fin       (state == FINISH),
            .track_val (track_val),
            .out_sign  (out_sign[o]),
            .out_mag   (out_mag[o])
        );
    end

    assign bus.outSign      = out_sign;
    assign bus.outMagnitude = out_mag;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_mix_scheduler.sv
module tb_mix_scheduler;
    import mix_pkg::*;

    localparam int NI = 4;
    localparam int NO = 4;

    logic clk = 1'b0;
    logic reset;

    mix_scheduler_if #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) bus();

    mix_scheduler #(
        .NUM_INPUTS (NI),
        .NUM_OUTPUTS(NO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NO-1:0]   s;
        magType [NO-1:0] m;
        int unsigned     at;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic magType pk(input int sat, input int nsat);
`ifdef MIX_SATURATE_EN
        return magType'(sat);
`else
        return magType'(nsat);
`endif
    endfunction

    // Monitor: a completed run is marked by busy falling.
    logic prev_busy = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (prev_busy && !bus.busy) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    for (int o = 0; o < NO; o++) begin
                        check($sformatf("lane%0d_sign_mag", o),
                              {23'd0, bus.outSign[o], bus.outMagnitude[o]},
                              {23'd0, e.s[o], e.m[o]});
                    end
                    check("latency_cycle", cyc, e.at);
                end
            end
            prev_busy = bus.busy;
        end
    end

    task automatic drive(input logic [NI-1:0] s, input magType [NI-1:0] m,
                         input logic [NO-1:0][NI-1:0] r);
        bus.sign      = s;
        bus.magnitude = m;
        bus.routeMask = r;
    endtask

    // Called at a negedge; strobes wgEn for edge k and queues the expected result.
    task automatic launch(input logic [NO-1:0] es, input magType [NO-1:0] em,
                          input int unsigned lat, output int unsigned k);
        exp_t e;
        k    = cyc + 1;
        e.s  = es;
        e.m  = em;
        e.at = k + lat;
        q.push_back(e);
        bus.wgEn = 1'b1;
        @(negedge clk);
        bus.wgEn = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("run_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    int unsigned k;

    initial begin
        reset = 1'b1;
        bus.wgEn = 1'b0;
        drive('0, '0, '0);

        // Reset, with a strobe arriving while reset is held.
        repeat (3) @(negedge clk);
        bus.wgEn = 1'b1;
        repeat (2) @(negedge clk);
        bus.wgEn = 1'b0;
        check("reset_outSign", {28'd0, bus.outSign}, 32'd0);
        check("reset_outMagnitude", bus.outMagnitude, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_busy", {31'd0, bus.busy}, 32'd0);

        // Run 1: two-track mix, all-zero mask, single negative track.
        drive(4'b1110, {8'd0, 8'd100, 8'd50, 8'd200},
              {4'b1000, 4'b0100, 4'b0000, 4'b0011});
        launch(4'b0100, {8'd0, pk(100, 25), 8'd0, pk(150, 37)}, 6, k);
        for (int i = 0; i < 6; i++) begin
            check("busy_during_run", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        check("busy_after_finish", {31'd0, bus.busy}, 32'd0);
        wait_done();

        // Run 2: full-scale tracks summed.
        drive(4'b0000, {8'd200, 8'd200, 8'd200, 8'd200},
              {4'b0000, 4'b0110, 4'b1111, 4'b0001});
        launch(4'b0000, {8'd0, pk(255, 100), pk(255, 200), pk(200, 50)}, 6, k);
        wait_done();

        // Run 3: cancellation, tiny negative, negative-zero track.
        drive(4'b1110, {8'd0, 8'd3, 8'd80, 8'd80},
              {4'b0011, 4'b1000, 4'b0100, 4'b0001});
        launch({2'b00, (pk(3, 0) != 8'd0), 1'b0}, {8'd0, 8'd0, pk(3, 0), pk(80, 20)}, 6, k);
        wait_done();

        // Run 4: inputs change after capture; result uses the snapshot.
        drive(4'b1001, {8'd30, 8'd20, 8'd10, 8'd0},
              {4'b0001, 4'b1000, 4'b0110, 4'b1110});
        launch(4'b0100, {8'd0, pk(30, 7), pk(30, 7), 8'd0}, 6, k);
        @(negedge clk);
        drive(4'b0000, {8'd255, 8'd255, 8'd255, 8'd255},
              {4'b1111, 4'b1111, 4'b1111, 4'b1111});
        wait_done();

        // Run 5: second strobe while busy.
        drive(4'b0000, {8'd200, 8'd200, 8'd200, 8'd200},
              {4'b0000, 4'b0110, 4'b1111, 4'b0001});
        launch(4'b0000, {8'd0, pk(255, 100), pk(255, 200), pk(200, 50)}, 6, k);
        check("overrun_before_second_strobe", {31'd0, bus.overrun}, 32'd0);
        repeat (2) @(negedge clk);
        bus.wgEn = 1'b1;
        @(negedge clk);
        bus.wgEn = 1'b0;
        check("overrun_set", {31'd0, bus.overrun}, 32'd1);
        wait_done();
        check("overrun_sticky", {31'd0, bus.overrun}, 32'd1);

        // Run 6: reset mid-run aborts it.
        drive(4'b0000, {8'd200, 8'd200, 8'd200, 8'd200},
              {4'b1111, 4'b1111, 4'b1111, 4'b1111});
        launch(4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 4, k);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_overrun", {31'd0, bus.overrun}, 32'd0);
        check("abort_outMagnitude", bus.outMagnitude, 32'd0);
        wait_done();
        repeat (10) @(negedge clk);
        check("abort_no_late_result", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
